top: RTL and testbench

- `top` is a single-clock asynchronous-SRAM access sequencer.
- A one-cycle `write` or `read` request starts a fixed-length burst of WORDS accesses.
- During a burst the block drives the SRAM strobes (`n_ce`, `n_oe`, `n_we`), a data-bus drive enable (`de`), a data/address latch strobe (`latch`) and an address-counter advance pulse (`count`).
- It sits between the user request logic and an external address counter, data latch and SRAM.

---
 rtl/top.sv | 126 ++++++++++++
 tb/tb_top.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/top.sv
//==============================================================================
// Module   : top
// Purpose  : Asynchronous-SRAM burst access sequencer (write/read bursts).
// Revision : 1.0
//==============================================================================
`default_nettype none

module top #(
    parameter int WORDS = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic read,
    input  logic write,
    output logic count,
    output logic latch,
    output logic de,
    output logic n_ce,
    output logic n_oe,
    output logic n_we
);

    localparam logic [3:0] c_last = 4'(WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_W_SETUP  = 3'd1,
        ST_W_STROBE = 3'd2,
        ST_W_HOLD   = 3'd3,
        ST_R_SETUP  = 3'd4,
        ST_R_ENABLE = 3'd5,
        ST_R_LATCH  = 3'd6
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_word;
    logic [3:0] w_word_next;
    logic       w_last;

    assign w_last = (r_word == c_last);

    always_comb begin
        w_next      = r_state;
        w_word_next = r_word;
        case (r_state)
            ST_IDLE: begin
                if (write)     w_next = ST_W_SETUP;
                else if (read) w_next = ST_R_SETUP;
            end
            ST_W_SETUP:  w_next = ST_W_STROBE;
            ST_W_STROBE: w_next = ST_W_HOLD;
            ST_W_HOLD: begin
                w_next      = w_last ? ST_IDLE : ST_W_SETUP;
                w_word_next = w_last ? 4'd0 : r_word + 4'd1;
            end
            ST_R_SETUP:  w_next = ST_R_ENABLE;
            ST_R_ENABLE: w_next = ST_R_LATCH;
            ST_R_LATCH: begin
                w_next      = w_last ? ST_IDLE : ST_R_SETUP;
                w_word_next = w_last ? 4'd0 : r_word + 4'd1;
            end
            default: begin
                w_next      = ST_IDLE;
                w_word_next = 4'd0;
            end
        endcase
    end

    // Outputs are registered from the next state so they always match r_state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_word  <= 4'd0;
            count   <= 1'b0;
            latch   <= 1'b0;
            de      <= 1'b0;
            n_ce    <= 1'b1;
            n_oe    <= 1'b1;
            n_we    <= 1'b1;
        end else begin
            r_state <= w_next;
            r_word  <= w_word_next;
            count   <= 1'b0;
            latch   <= 1'b0;
            de      <= 1'b0;
            n_ce    <= 1'b1;
            n_oe    <= 1'b1;
            n_we    <= 1'b1;
            case (w_next)
                ST_W_SETUP: begin
                    latch <= 1'b1;
                    de    <= 1'b1;
                    n_ce  <= 1'b0;
                end
                ST_W_STROBE: begin
                    de   <= 1'b1;
                    n_ce <= 1'b0;
                    n_we <= 1'b0;
                end
                ST_W_HOLD: begin
                    de    <= 1'b1;
                    n_ce  <= 1'b0;
                    count <= 1'b1;
                end
                ST_R_SETUP: begin
                    n_ce <= 1'b0;
                end
                ST_R_ENABLE: begin
                    n_ce <= 1'b0;
                    n_oe <= 1'b0;
                end
                ST_R_LATCH: begin
                    n_ce  <= 1'b0;
                    n_oe  <= 1'b0;
                    latch <= 1'b1;
                    count <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_top.sv
//==============================================================================
// Module   : tb_top
// Purpose  : Self-checking bench for top against a burst-position model.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_top;

    localparam int WORDS = 4;
    localparam int c_len = 3 * WORDS;

    logic clock = 1'b0;
    logic reset;
    logic read;
    logic write;
    logic count, latch, de, n_ce, n_oe, n_we;

    int checks   = 0;
    int failures = 0;

    // Model: 0 = idle, 1 = write burst, 2 = read burst; pos = cycle within burst.
    int mode = 0;
    int pos  = 0;
    int idle_seen;

    top #(.WORDS(WORDS)) dut (
        .clock (clock),
        .reset (reset),
        .read  (read),
        .write (write),
        .count (count),
        .latch (latch),
        .de    (de),
        .n_ce  (n_ce),
        .n_oe  (n_oe),
        .n_we  (n_we)
    );

    always #5 clock = ~clock;

    // Expected {count,latch,de,n_ce,n_oe,n_we} from burst type and phase.
    function automatic logic [5:0] expected_outputs();
        int ph;
        ph = pos % 3;
        if (mode == 1) begin
            if (ph == 0) return 6'b011011;
            if (ph == 1) return 6'b001010;
            return 6'b101011;
        end
        if (mode == 2) begin
            if (ph == 0) return 6'b000011;
            if (ph == 1) return 6'b000001;
            return 6'b110001;
        end
        return 6'b000111;
    endfunction

    task automatic model_edge(input logic w, input logic r);
        if (mode == 0) begin
            if (w) begin
                mode = 1;
                pos  = 0;
            end else if (r) begin
                mode = 2;
                pos  = 0;
            end
        end else begin
            pos = pos + 1;
            if (pos == c_len) begin
                mode = 0;
                pos  = 0;
            end
        end
    endtask

    task automatic check(input string tag);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = {count, latch, de, n_ce, n_oe, n_we};
        exp = expected_outputs();
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: outputs {count,latch,de,n_ce,n_oe,n_we} observed=%b expected=%b (mode=%0d pos=%0d)",
                   tag, obs, exp, mode, pos);
        end
        checks++;
        assert ((de && !n_oe) === 1'b0) else begin
            failures++;
            $error("FAIL %s_contention: de=%b n_oe=%b observed overlap, expected none", tag, de, n_oe);
        end
    endtask

    // Called just after a negedge: drive inputs, take one rising edge, check.
    task automatic step(input logic w, input logic r, input string tag);
        write = w;
        read  = r;
        @(posedge clock);
        if (reset) begin
            mode = 0;
            pos  = 0;
        end else begin
            model_edge(w, r);
        end
        #1;
        check(tag);
        @(negedge clock);
    endtask

    task automatic async_reset(input int dly, input string tag);
        #(dly);
        reset = 1'b1;
        mode  = 0;
        pos   = 0;
        #1;
        check(tag);
        @(posedge clock);
        #1;
        check(tag);
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        write = 1'b0;
        read  = 1'b0;
        #2;
        check("reset_hold");
        @(posedge clock);
        #1;
        check("reset_hold_edge");
        @(negedge clock);
        reset = 1'b0;
        step(1'b0, 1'b0, "post_reset");
        step(1'b0, 1'b0, "post_reset");

        // Single write burst, then a read burst well after it.
        step(1'b1, 1'b0, "write_burst");
        repeat (c_len + 1) step(1'b0, 1'b0, "write_burst");
        step(1'b0, 1'b1, "read_burst");
        repeat (c_len + 1) step(1'b0, 1'b0, "read_burst");

        // Read request while busy with a write must be dropped.
        step(1'b1, 1'b0, "busy");
        repeat (4) step(1'b0, 1'b0, "busy");
        step(1'b0, 1'b1, "busy_read_ignored");
        repeat (c_len) step(1'b0, 1'b0, "busy");

        // Simultaneous requests: write takes priority.
        step(1'b1, 1'b1, "both_req");
        repeat (c_len + 1) step(1'b0, 1'b0, "both_req");

        // Reset during W_STROBE, then a complete fresh burst.
        step(1'b1, 1'b0, "mid_reset");
        step(1'b0, 1'b0, "mid_reset_strobe");
        async_reset(1, "mid_reset_async");
        step(1'b1, 1'b0, "after_reset");
        repeat (c_len + 1) step(1'b0, 1'b0, "after_reset");

        // Held write: back-to-back bursts with a single idle cycle between.
        idle_seen = 0;
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 1'b0, "held_write");
            if (n_ce === 1'b1) idle_seen++;
        end
        checks++;
        assert (idle_seen === 2) else begin
            failures++;
            $error("FAIL held_idle_cycles: observed=%0d expected=%0d", idle_seen, 2);
        end
        repeat (c_len + 2) step(1'b0, 1'b0, "held_drain");

        // Random requests with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 79) == 0)
                async_reset(int'($urandom_range(1, 3)), "rand_reset");
            else
                step(logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 5) == 0), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
